// File: rtl/sbox_scheduler.sv
// Shares one bank of SBOX_W S-box lanes between the round datapath (SubBytes,
// one state row per cycle) and the key schedule (SubWord, one cycle).
// Optional feature macro: SBOX_SCHED_RR_EN selects round-robin arbitration
// between the two requesters; when undefined the key schedule has fixed priority.
module sbox_scheduler #(
  parameter int unsigned SBOX_W = 4,
  parameter int unsigned SBOX_H = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       d_valid,
  input  logic [SBOX_H*SBOX_W*8-1:0] d_state,
  output logic                       d_done,
  output logic [SBOX_H*SBOX_W*8-1:0] d_result,
  input  logic                       k_valid,
  input  logic [SBOX_W*8-1:0]        k_word,
  output logic                       k_done,
  output logic [SBOX_W*8-1:0]        k_result,
  output logic [SBOX_W*8-1:0]        sbox_in,
  input  logic [SBOX_W*8-1:0]        sbox_out,
  output logic                       busy
);

  localparam int unsigned RowW   = SBOX_W * 8;
  localparam int unsigned StateW = SBOX_H * RowW;
  localparam int unsigned CntW   = (SBOX_H > 1) ? $clog2(SBOX_H) : 1;

  typedef enum logic [2:0] {StIdle, StData, StKey, StDDone, StKDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     row_cnt_q, row_cnt_d;
  logic [StateW-1:0]   d_result_q, d_result_d;
  logic [RowW-1:0]     k_result_q, k_result_d;
  logic                grant_key;

`ifdef SBOX_SCHED_RR_EN
  // 1: key won the last contested arbitration, 0: data did.
  logic last_grant_q, last_grant_d;

  assign grant_key = k_valid && (!d_valid || !last_grant_q);

  // Only contested arbitrations move the pointer, so a lone request never uses up a turn.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StIdle && k_valid && d_valid) begin
      last_grant_d = grant_key;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_key = k_valid;
`endif

  // Next-state, lane steering and result capture.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    d_result_d = d_result_q;
    k_result_d = k_result_q;
    sbox_in    = '0;
    d_done     = 1'b0;
    k_done     = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (grant_key) begin
          state_d = StKey;
        end else if (d_valid) begin
          state_d   = StData;
          row_cnt_d = '0;
        end
      end
      StData: begin
        sbox_in = d_state[32'(row_cnt_q) * RowW +: RowW];
        d_result_d[32'(row_cnt_q) * RowW +: RowW] = sbox_out;
        if (row_cnt_q == CntW'(SBOX_H - 1)) begin
          row_cnt_d = '0;
          state_d   = StDDone;
        end else begin
          row_cnt_d = row_cnt_q + CntW'(1);
        end
      end
      StKey: begin
        sbox_in    = k_word;
        k_result_d = sbox_out;
        state_d    = StKDone;
      end
      StDDone: begin
        d_done  = 1'b1;
        state_d = StIdle;
      end
      StKDone: begin
        k_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, row counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_cnt_q  <= '0;
      d_result_q <= '0;
      k_result_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      d_result_q <= d_result_d;
      k_result_q <= k_result_d;
    end
  end

  assign d_result = d_result_q;
  assign k_result = k_result_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler: a per-cycle vector table for single data
// and key operations, plus sequences for contention, no-preemption and reset.
module tb_sbox_scheduler;

  logic         clk;
  logic         rst_n;
  logic         d_valid;
  logic [127:0] d_state;
  logic         d_done;
  logic [127:0] d_result;
  logic         k_valid;
  logic [31:0]  k_word;
  logic         k_done;
  logic [31:0]  k_result;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         busy;

  int errors = 0;
  int checks = 0;

  sbox_scheduler #(.SBOX_W(4), .SBOX_H(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_valid  (d_valid),
    .d_state  (d_state),
    .d_done   (d_done),
    .d_result (d_result),
    .k_valid  (k_valid),
    .k_word   (k_word),
    .k_done   (k_done),
    .k_result (k_result),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AES forward S-box, standing in for the combinational lane bank.
  logic [7:0] sbox_rom [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Lane bank model: each lane looks up its own byte.
  always_comb begin
    sbox_out = '0;
    for (int k = 0; k < 4; k++) begin
      sbox_out[k*8 +: 8] = sbox_rom[sbox_in[k*8 +: 8]];
    end
  end

  localparam logic [127:0] Z   = 128'h0;
  localparam logic [127:0] S1  = 128'h00000000_00000000_00000000_63636363;
  localparam logic [127:0] S2  = 128'h00000000_00000000_63636363_63636363;
  localparam logic [127:0] S3  = 128'h00000000_63636363_63636363_63636363;
  localparam logic [127:0] S63 = 128'h63636363_63636363_63636363_63636363;
  localparam logic [127:0] FI  = 128'h193DE3BE_A0F4E22B_9AC68D2A_E9F84808;
  localparam logic [127:0] F1  = 128'h63636363_63636363_63636363_1E415230;
  localparam logic [127:0] F2  = 128'h63636363_63636363_B8B45DE5_1E415230;
  localparam logic [127:0] F3  = 128'h63636363_E0BF98F1_B8B45DE5_1E415230;
  localparam logic [127:0] FO  = 128'hD42711AE_E0BF98F1_B8B45DE5_1E415230;
  localparam logic [31:0]  KW  = 32'hFF53_0100;
  localparam logic [31:0]  KR  = 32'h16ED_7C63;

  // Inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic         dv;
    logic         kv;
    logic [127:0] ds;
    logic [31:0]  kw;
    logic         e_dd;
    logic         e_kd;
    logic         e_busy;
    logic [31:0]  e_sin;
    logic [127:0] e_dres;
    logic [31:0]  e_kres;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Raise valids at given cycle indices (-1 = never), drop each on its done,
  // and compare the cycle in which each done pulse appeared.
  task automatic run_seq(input string nm, input int d_at, input int k_at,
                         input int exp_dd, input int exp_kd);
    int dd_cyc;
    int kd_cyc;
    dd_cyc = -1;
    kd_cyc = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == d_at) d_valid = 1'b1;
      if (cyc == k_at) k_valid = 1'b1;
      tick();
      if (d_done) begin
        if (dd_cyc < 0) dd_cyc = cyc + 1;
        d_valid = 1'b0;
      end
      if (k_done) begin
        if (kd_cyc < 0) kd_cyc = cyc + 1;
        k_valid = 1'b0;
      end
    end
    chk({nm, " d_done cycle"}, 128'(dd_cyc), 128'(exp_dd));
    chk({nm, " k_done cycle"}, 128'(kd_cyc), 128'(exp_kd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vecs[0]  = '{1'b1, 1'b0, Z,  32'h0, 1'b0, 1'b0, 1'b1, 32'h0,        Z,   32'h0};
    vecs[1]  = '{1'b1, 1'b0, Z,  32'h0, 1'b0, 1'b0, 1'b1, 32'h0,        S1,  32'h0};
    vecs[2]  = '{1'b1, 1'b0, Z,  32'h0, 1'b0, 1'b0, 1'b1, 32'h0,        S2,  32'h0};
    vecs[3]  = '{1'b1, 1'b0, Z,  32'h0, 1'b0, 1'b0, 1'b1, 32'h0,        S3,  32'h0};
    vecs[4]  = '{1'b1, 1'b0, Z,  32'h0, 1'b1, 1'b0, 1'b1, 32'h0,        S63, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, Z,  32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        S63, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, FI, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE9F84808, S63, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, FI, 32'h0, 1'b0, 1'b0, 1'b1, 32'h9AC68D2A, F1,  32'h0};
    vecs[8]  = '{1'b1, 1'b0, FI, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA0F4E22B, F2,  32'h0};
    vecs[9]  = '{1'b1, 1'b0, FI, 32'h0, 1'b0, 1'b0, 1'b1, 32'h193DE3BE, F3,  32'h0};
    vecs[10] = '{1'b1, 1'b0, FI, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0,        FO,  32'h0};
    vecs[11] = '{1'b0, 1'b0, FI, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        FO,  32'h0};
    vecs[12] = '{1'b0, 1'b1, FI, KW,    1'b0, 1'b0, 1'b1, KW,           FO,  32'h0};
    vecs[13] = '{1'b0, 1'b1, FI, KW,    1'b0, 1'b1, 1'b1, 32'h0,        FO,  KR};
    vecs[14] = '{1'b0, 1'b0, FI, KW,    1'b0, 1'b0, 1'b0, 32'h0,        FO,  KR};

    rst_n   = 1'b0;
    d_valid = 1'b0;
    k_valid = 1'b0;
    d_state = '0;
    k_word  = '0;
    #12;
    chk("reset d_done", 128'(d_done), 128'(0));
    chk("reset k_done", 128'(k_done), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset sbox_in", 128'(sbox_in), 128'(0));
    chk("reset d_result", d_result, Z);
    chk("reset k_result", 128'(k_result), 128'(0));
    rst_n = 1'b1;

    // Single data operations (zero state, FIPS-197 state) and one key word.
    for (int i = 0; i < 15; i++) begin
      d_valid = vecs[i].dv;
      k_valid = vecs[i].kv;
      d_state = vecs[i].ds;
      k_word  = vecs[i].kw;
      tick();
      chk($sformatf("vec%0d d_done", i), 128'(d_done), 128'(vecs[i].e_dd));
      chk($sformatf("vec%0d k_done", i), 128'(k_done), 128'(vecs[i].e_kd));
      chk($sformatf("vec%0d busy", i), 128'(busy), 128'(vecs[i].e_busy));
      chk($sformatf("vec%0d sbox_in", i), 128'(sbox_in), 128'(vecs[i].e_sin));
      chk($sformatf("vec%0d d_result", i), d_result, vecs[i].e_dres);
      chk($sformatf("vec%0d k_result", i), 128'(k_result), 128'(vecs[i].e_kres));
    end

    // Simultaneous requests: key wins the first contest in both arbitration modes.
    d_state = FI;
    k_word  = KW;
    run_seq("pair1", 0, 0, 8, 2);
    chk("pair1 d_result", d_result, FO);
    chk("pair1 k_result", 128'(k_result), 128'(KR));
`ifdef SBOX_SCHED_RR_EN
    run_seq("pair2", 0, 0, 5, 8);
`else
    run_seq("pair2", 0, 0, 8, 2);
`endif

    // Key arriving during DATA row 1 waits for the data op and one IDLE cycle.
    d_state = Z;
    run_seq("nopreempt", 0, 2, 5, 8);
    chk("nopreempt d_result", d_result, S63);

    // Asynchronous reset in DATA row 2 aborts without a done pulse.
    d_state = FI;
    d_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("pre-reset sbox_in row2", 128'(sbox_in), 128'(32'hA0F4E22B));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort d_done", 128'(d_done), 128'(0));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort sbox_in", 128'(sbox_in), 128'(0));
    chk("abort d_result", d_result, Z);
    chk("abort k_result", 128'(k_result), 128'(0));
    d_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_done || k_done || busy) pulses++;
    end
    chk("abort no activity", 128'(pulses), 128'(0));
    run_seq("fresh", 0, -1, 5, -1);
    chk("fresh d_result", d_result, FO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
